// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter
//   Round-robin read scheduler for NUM_SRC async-FIFO read sides in the rclk domain.
//   It watches each FIFO's registered empty flag and issues single-cycle one-hot r_en
//   pops, one source at a time. It captures the FIFO's registered read data one cycle
//   after the pop and presents it on a valid/ready stream, tagged with the source index.
//
// Ports
//   rclk       in   read-domain clock
//   rrst       in   asynchronous reset, active high
//   empty      in   per-FIFO registered empty flag
//   rdata      in   per-FIFO read data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   r_en       out  one-hot pop strobe, registered, high only in READ
//   out_valid  out  output word valid
//   out_ready  in   consumer accepts word
//   out_data   out  captured word
//   out_src    out  source index of out_data
//
// Build option
//   ARB_BURST_EN  When defined, the arbiter keeps granting the same source for up to
//                 BURST_LEN consecutive words while that source stays non-empty. These
//                 follow-on words go HOLD -> READ directly, so each takes 3 cycles. When
//                 undefined, the arbiter is strict one-word round robin and does not use
//                 BURST_LEN.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | search for a non-empty source starting at rr_ptr
// READ  | r_en high for this one cycle; pop refused if source empty
// CAPT  | FIFO read data valid, capture into output register
// HOLD  | out_valid high, wait for out_ready handshake

module fifo_rd_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                          rclk,
    input  logic                          rrst,
    input  logic [NUM_SRC-1:0]            empty,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] rdata,
    output logic [NUM_SRC-1:0]            r_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(NUM_SRC)-1:0]    out_src
);

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam logic [NUM_SRC-1:0] ONE_HOT0 = NUM_SRC'(1);

    if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
        $error("fifo_rd_arbiter: NUM_SRC must be in 2..16");
    end
    if (BURST_LEN < 1) begin : g_bad_burst_len
        $error("fifo_rd_arbiter: BURST_LEN must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CAPT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [SRC_W-1:0]      rr_ptr, rr_ptr_nxt;
    logic [SRC_W-1:0]      grant, grant_nxt;
    logic [NUM_SRC-1:0]    r_en_nxt;
    logic                  out_valid_nxt;
    logic [DATA_WIDTH-1:0] out_data_nxt;
    logic [SRC_W-1:0]      out_src_nxt;

    logic [DATA_WIDTH-1:0] rdata_arr [NUM_SRC];
    logic                  rr_found;
    logic [SRC_W-1:0]      rr_pick;
    logic [SRC_W:0]        rr_idx;
    logic [SRC_W-1:0]      grant_inc;
    logic                  burst_more;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign rdata_arr[i] = rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // rr_ptr is always < NUM_SRC, so one conditional subtract wraps the search
    // index even when NUM_SRC is not a power of two.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            rr_idx = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (rr_idx >= (SRC_W+1)'(NUM_SRC)) begin
                rr_idx = rr_idx - (SRC_W+1)'(NUM_SRC);
            end
            if (!rr_found && !empty[rr_idx[SRC_W-1:0]]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx[SRC_W-1:0];
            end
        end
    end

    assign grant_inc = (grant == SRC_W'(NUM_SRC-1)) ? '0 : grant + 1'b1;

`ifdef ARB_BURST_EN
    localparam int CNT_W = $clog2(BURST_LEN+1);
    logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;

    // burst_cnt holds the number of extra grants already given to this source,
    // so BURST_LEN-1 follow-on grants cap the run at BURST_LEN words.
    assign burst_more = !empty[grant] && (burst_cnt < CNT_W'(BURST_LEN-1));
`else
    assign burst_more = 1'b0;
`endif

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            r_en      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
`ifdef ARB_BURST_EN
            burst_cnt <= '0;
`endif
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            grant     <= grant_nxt;
            r_en      <= r_en_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            out_src   <= out_src_nxt;
`ifdef ARB_BURST_EN
            burst_cnt <= burst_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (rr_found) state_nxt = READ;
            READ: state_nxt = empty[grant] ? IDLE : CAPT;
            CAPT: state_nxt = HOLD;
            HOLD: if (out_ready) state_nxt = burst_more ? READ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        r_en_nxt      = '0;
        grant_nxt     = grant;
        rr_ptr_nxt    = rr_ptr;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        out_src_nxt   = out_src;
`ifdef ARB_BURST_EN
        burst_cnt_nxt = burst_cnt;
`endif
        case (state)
            IDLE: begin
                if (rr_found) begin
                    grant_nxt = rr_pick;
                    r_en_nxt  = ONE_HOT0 << rr_pick;
`ifdef ARB_BURST_EN
                    burst_cnt_nxt = '0;
`endif
                end
            end
            CAPT: begin
                out_data_nxt  = rdata_arr[grant];
                out_src_nxt   = grant;
                out_valid_nxt = 1'b1;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    if (burst_more) begin
                        r_en_nxt = ONE_HOT0 << grant;
`ifdef ARB_BURST_EN
                        burst_cnt_nxt = burst_cnt + 1'b1;
`endif
                    end else begin
                        rr_ptr_nxt = grant_inc;
`ifdef ARB_BURST_EN
                        burst_cnt_nxt = '0;
`endif
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
module tb_fifo_rd_arbiter;

    logic        rclk = 1'b0;
    logic        rrst = 1'b1;
    logic [3:0]  empty;
    logic [31:0] rdata;
    logic [3:0]  r_en;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [1:0]  out_src;

    fifo_rd_arbiter #(
        .NUM_SRC    (4),
        .DATA_WIDTH (8),
        .BURST_LEN  (4)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .empty     (empty),
        .rdata     (rdata),
        .r_en      (r_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    always #5 rclk = ~rclk;

    // FIFO read-side model: registered empty and one-cycle read latency
    logic [7:0] mem    [4][16];
    logic [3:0] wr_cnt [4] = '{default: 4'd0};
    logic [3:0] rd_idx [4] = '{default: 4'd0};
    logic [7:0] rd_q   [4] = '{default: 8'd0};

    for (genvar i = 0; i < 4; i++) begin : g_fifo
        assign empty[i]         = (rd_idx[i] == wr_cnt[i]);
        assign rdata[i*8 +: 8]  = rd_q[i];
    end

    always @(posedge rclk) begin
        for (int i = 0; i < 4; i++) begin
            if (r_en[i] && !empty[i]) begin
                rd_q[i]   <= mem[i][rd_idx[i]];
                rd_idx[i] <= rd_idx[i] + 4'd1;
            end
        end
    end

    // handshake and r_en monitor, sampled mid-cycle
    logic [1:0] got_src [$];
    logic [7:0] got_dat [$];
    int         ren_cyc     = 0;
    int         onehot_viol = 0;

    always @(negedge rclk) begin
        if (out_valid && out_ready) begin
            got_src.push_back(out_src);
            got_dat.push_back(out_data);
        end
        if (r_en != 4'd0) ren_cyc++;
        if ((r_en & (r_en - 4'd1)) != 4'd0) onehot_viol++;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #2;
    endtask

    task automatic push(input int s, input logic [7:0] d);
        mem[s][wr_cnt[s]] = d;
        wr_cnt[s] = wr_cnt[s] + 4'd1;
    endtask

    task automatic wait_got(input int n, input int budget, input string tag);
        int t;
        t = 0;
        while (got_src.size() < n && t < budget) begin
            tick();
            t++;
        end
        chk(tag, got_src.size(), n);
    endtask

`ifdef ARB_BURST_EN
    logic [1:0] t3_s [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    logic [7:0] t3_d [8] = '{8'h40, 8'h41, 8'h50, 8'h51, 8'h60, 8'h61, 8'h70, 8'h71};
    logic [1:0] t6_s [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
    logic [7:0] t6_d [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hA4, 8'hA5};
`else
    logic [1:0] t3_s [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [7:0] t3_d [8] = '{8'h40, 8'h50, 8'h60, 8'h70, 8'h41, 8'h51, 8'h61, 8'h71};
    logic [1:0] t6_s [8] = '{0, 1, 0, 1, 0, 0, 0, 0};
    logic [7:0] t6_d [8] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
`endif

    initial begin
        int b;
        int rc0;
        int t;

        // reset with all FIFOs empty
        repeat (3) tick();
        chk("t1_rst_ren",   r_en,      0);
        chk("t1_rst_valid", out_valid, 0);
        chk("t1_rst_src",   out_src,   0);
        chk("t1_rst_data",  out_data,  0);
        rrst = 1'b0;
        repeat (4) tick();
        chk("t1_idle_ren",   r_en,      0);
        chk("t1_idle_valid", out_valid, 0);
        chk("t1_idle_src",   out_src,   0);

        // single source, 3 words
        out_ready = 1'b1;
        b   = got_src.size();
        rc0 = ren_cyc;
        push(1, 8'hA1);
        push(1, 8'hB2);
        push(1, 8'hC3);
        tick();
        chk("t2_ren_first", r_en, 4'b0010);
        tick();
        chk("t2_ren_drop",  r_en, 4'b0000);
        chk("t2_valid_lo",  out_valid, 0);
        tick();
        chk("t2_valid_hi",  out_valid, 1);
        chk("t2_data0",     out_data, 8'hA1);
        chk("t2_src0",      out_src, 1);
        wait_got(b + 3, 40, "t2_count");
        chk("t2_d1", got_dat[b+1], 8'hB2);
        chk("t2_d2", got_dat[b+2], 8'hC3);
        chk("t2_s1", got_src[b+1], 1);
        chk("t2_s2", got_src[b+2], 1);
        repeat (2) tick();
        chk("t2_ren_pulses", ren_cyc - rc0, 3);

        // round robin over all four sources, starting from rr_ptr=0
        rrst = 1'b1;
        tick();
        rrst = 1'b0;
        b = got_src.size();
        for (int s = 0; s < 4; s++) begin
            push(s, 8'h40 + 8'(s * 16));
            push(s, 8'h41 + 8'(s * 16));
        end
        wait_got(b + 8, 80, "t3_count");
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_src%0d", i), got_src[b+i], t3_s[i]);
            chk($sformatf("t3_dat%0d", i), got_dat[b+i], t3_d[i]);
        end

        // backpressure on src2
        out_ready = 1'b0;
        b = got_src.size();
        push(2, 8'hE0);
        push(2, 8'hE1);
        t = 0;
        while (!out_valid && t < 20) begin
            tick();
            t++;
        end
        chk("t4_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("t4_hold%0d", i), {out_valid, out_src, out_data, r_en},
                {1'b1, 2'd2, 8'hE0, 4'b0000});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_valid_drop", out_valid, 0);
`ifdef ARB_BURST_EN
        chk("t4_next_ren", r_en, 4'b0100);
`else
        chk("t4_idle_ren", r_en, 4'b0000);
        tick();
        chk("t4_next_ren", r_en, 4'b0100);
`endif
        out_ready = 1'b1;
        wait_got(b + 2, 40, "t4_count");
        chk("t4_s0", got_src[b],   2);
        chk("t4_d0", got_dat[b],   8'hE0);
        chk("t4_s1", got_src[b+1], 2);
        chk("t4_d1", got_dat[b+1], 8'hE1);

        // reset while in CAPT: popped word dropped, arbitration restarts at src0
        b = got_src.size();
        push(3, 8'hD3);
        push(3, 8'hD4);
        push(1, 8'h91);
        tick();
        chk("t5_ren_pre", r_en, 4'b1000);
        tick();
        rrst = 1'b1;
        #1;
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_ren",   r_en,      0);
        tick();
        chk("t5_rst_hold_valid", out_valid, 0);
        rrst = 1'b0;
        wait_got(b + 2, 40, "t5_count");
        chk("t5_s0", got_src[b],   1);
        chk("t5_d0", got_dat[b],   8'h91);
        chk("t5_s1", got_src[b+1], 3);
        chk("t5_d1", got_dat[b+1], 8'hD4);

        // src0 with 6 words, src1 with 2
        b = got_src.size();
        for (int i = 0; i < 6; i++) push(0, 8'hA0 + 8'(i));
        push(1, 8'hB0);
        push(1, 8'hB1);
        wait_got(b + 8, 80, "t6_count");
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t6_src%0d", i), got_src[b+i], t6_s[i]);
            chk($sformatf("t6_dat%0d", i), got_dat[b+i], t6_d[i]);
        end

        chk("ren_onehot", onehot_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
